// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(15,11) encoder with an output FIFO,
// a one-shot bit-flip injector and a delivered-word counter.
module hamming_encoder_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [14:0]      out_code,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             inj_req,
    input  logic [3:0]       inj_pos,
    output logic             inj_armed,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [14:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_inj_armed;
    logic [3:0]       r_inj_pos;
    logic [CNT_W-1:0] r_word_cnt;

    logic [14:0]      w_code;
    logic [14:0]      w_mask;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;

    assign w_in_ready  = !rst && (r_count != FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_code  = w_out_valid ? r_mem[r_rd_ptr] : 15'd0;
    assign inj_armed = r_inj_armed;
    assign word_cnt  = r_word_cnt;

    // Place data bits and compute the four parity bits.
    always_comb begin
        w_code      = '0;
        w_code[2]   = in_data[0];
        w_code[4]   = in_data[1];
        w_code[5]   = in_data[2];
        w_code[6]   = in_data[3];
        w_code[14:8] = in_data[10:4];
        w_code[0] = w_code[2] ^ w_code[4] ^ w_code[6] ^ w_code[8]
                  ^ w_code[10] ^ w_code[12] ^ w_code[14];
        w_code[1] = w_code[2] ^ w_code[5] ^ w_code[6] ^ w_code[9]
                  ^ w_code[10] ^ w_code[13] ^ w_code[14];
        w_code[3] = w_code[4] ^ w_code[5] ^ w_code[6] ^ w_code[11]
                  ^ w_code[12] ^ w_code[13] ^ w_code[14];
        w_code[7] = ^w_code[14:8];
    end

    // Flip mask for an armed injection; position 15 flips nothing.
    always_comb begin
        w_mask = '0;
        if (r_inj_armed && (r_inj_pos != 4'd15))
            w_mask = 15'(1) << r_inj_pos;
    end

    // Codeword storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_code ^ w_mask;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Injection arm: a new request wins over consumption by an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_armed <= 1'b0;
            r_inj_pos   <= 4'd0;
        end else if (inj_req) begin
            r_inj_armed <= 1'b1;
            r_inj_pos   <= inj_pos;
        end else if (w_push) begin
            r_inj_armed <= 1'b0;
        end
    end

    // Count delivered codewords, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst)
            r_word_cnt <= '0;
        else if (w_pop)
            r_word_cnt <= r_word_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Scoreboard bench for hamming_encoder_stream: directed
// vectors, back-pressure, injection, reset and random traffic.
module tb_hamming_encoder_stream;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [10:0]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [14:0]      out_code;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             inj_req = 1'b0;
    logic [3:0]       inj_pos = '0;
    logic             inj_armed;
    logic [CNT_W-1:0] word_cnt;

    hamming_encoder_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_code(out_code), .out_valid(out_valid),
        .out_ready(out_ready),
        .inj_req(inj_req), .inj_pos(inj_pos), .inj_armed(inj_armed),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    logic [14:0] sb[$];
    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_xfer = 0;
    bit          bp_en  = 1'b0;
    bit          hold_v = 1'b0;
    logic [14:0] hold_code = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Positional reference: data fills non-power-of-two positions,
    // parity 2^k covers every position with bit k set.
    function automatic logic [14:0] enc(input logic [10:0] d);
        logic [14:0] cw;
        int          k;
        logic        par;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++)
                if (((p >> b) & 1) == 1) par ^= cw[p-1];
            cw[(1 << b) - 1] = par;
        end
        return cw;
    endfunction

    // Monitor: pop and compare on every transfer; check stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold_stable", int'(out_code), int'(hold_code));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got 'h%0h, expected none",
                             out_code);
                end else begin
                    chk("out_code", int'(out_code), int'(sb.pop_front()));
                end
                n_xfer++;
            end
            hold_v    = out_valid && !out_ready;
            hold_code = out_code;
        end
    end

    // Background random output back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_try(input logic [10:0] d, input logic [14:0] e,
                            input int budget, output bit ok);
        in_data  = d;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [10:0] d, input logic [14:0] e);
        bit ok;
        send_try(d, e, 200, ok);
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int acc;
        bit ok;
        logic [10:0] d;

        // Reset state.
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        tick(2);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_inj_armed", int'(inj_armed), 0);
        chk("rst_word_cnt", int'(word_cnt), 0);
        chk("rst_out_code", int'(out_code), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Basic vectors and first-word latency.
        out_ready = 1'b1;
        send(11'h000, 15'h0000);
        chk("latency_valid", int'(out_valid), 1);
        send(11'h7FF, 15'h7FFF);
        send(11'h001, 15'h0007);
        drain(20);
        tick(2);
        chk("word_cnt_3", int'(word_cnt), 3);

        // Fill with no drain; in_ready must drop after DEPTH accepts.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            d = 11'(12'h0A5 + 12'(i * 37));
            send_try(d, enc(d), 3, ok);
            if (ok) acc++;
            else break;
        end
        chk("full_accepts", acc, DEPTH);
        chk("full_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        chk("full_no_comb_path", int'(in_ready), 0);
        drain(50);
        send(11'h155, enc(11'h155));
        send(11'h2AA, enc(11'h2AA));
        drain(20);

        // Injection at position 5, then clean word.
        inj_pos = 4'd5;
        inj_req = 1'b1;
        tick(1);
        inj_req = 1'b0;
        chk("inj_armed_set", int'(inj_armed), 1);
        send(11'h000, 15'h0020);
        chk("inj_armed_clr", int'(inj_armed), 0);
        send(11'h000, 15'h0000);
        drain(20);

        // Injection at position 15 flips nothing but is consumed.
        inj_pos = 4'd15;
        inj_req = 1'b1;
        tick(1);
        inj_req = 1'b0;
        send(11'h7FF, 15'h7FFF);
        chk("inj15_armed_clr", int'(inj_armed), 0);
        drain(20);

        // Reset mid-operation discards FIFO and armed injection.
        out_ready = 1'b0;
        send(11'h001, 15'h0007);
        send(11'h002, enc(11'h002));
        send(11'h003, enc(11'h003));
        inj_pos = 4'd3;
        inj_req = 1'b1;
        tick(1);
        inj_req = 1'b0;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        tick(1);
        rst    = 1'b0;
        n_xfer = 0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_inj_armed", int'(inj_armed), 0);
        chk("mid_rst_word_cnt", int'(word_cnt), 0);
        out_ready = 1'b1;
        send(11'h001, 15'h0007);
        drain(20);

        // Random traffic with back-pressure.
        bp_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            d = 11'($urandom);
            send(d, enc(d));
        end
        bp_en = 1'b0;
        tick(1);
        out_ready = 1'b1;
        drain(100);
        tick(2);
        chk("word_cnt_total", int'(word_cnt), n_xfer % (1 << CNT_W));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
